// File: rtl/msrv32_pkg.sv
// Shared definitions for the msrv32 pipeline.
//   - SZ_*  : load/store size codes as carried from stage 2 (2'b11 behaves as word)
//   - lsu_state_e : load/store unit FSM encoding
//   - WB_*  : write-back mux select codes
//   - is_misaligned() : natural-alignment check for a size/offset pair
package msrv32_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_BUSY = 2'd1,
        LSU_RESP = 2'd2
    } lsu_state_e;

    localparam logic [2:0] WB_ALU    = 3'd0;
    localparam logic [2:0] WB_LU     = 3'd1;
    localparam logic [2:0] WB_IMM    = 3'd2;
    localparam logic [2:0] WB_IADDER = 3'd3;
    localparam logic [2:0] WB_CSR    = 3'd4;
    localparam logic [2:0] WB_PC4    = 3'd5;

    // Halfwords need offset bit 0 clear; words (and size 2'b11) need both clear.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        if (size == SZ_H) begin
            mis = off[0];
        end else if (size[1]) begin
            mis = (off != 2'b00);
        end
        return mis;
    endfunction

endpackage

// File: rtl/msrv32_load_align.sv
// Load data alignment: picks the addressed byte/halfword out of a 32-bit bus
// word and sign- or zero-extends it to 32 bits. Purely combinational.
//   rdata_in    : raw 32-bit word from the data bus
//   offset_in   : byte offset of the access within the word (addr[1:0])
//   size_in     : SZ_B / SZ_H / SZ_W (2'b11 treated as word)
//   unsigned_in : 1 = zero-extend, 0 = sign-extend
//   data_out    : aligned, extended result
module msrv32_load_align
    import msrv32_pkg::*;
(
    input  logic [31:0] rdata_in,
    input  logic [1:0]  offset_in,
    input  logic [1:0]  size_in,
    input  logic        unsigned_in,
    output logic [31:0] data_out
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        ext_bit;

    always_comb begin
        byte_sel = rdata_in[7:0];
        case (offset_in)
            2'd0:    byte_sel = rdata_in[7:0];
            2'd1:    byte_sel = rdata_in[15:8];
            2'd2:    byte_sel = rdata_in[23:16];
            default: byte_sel = rdata_in[31:24];
        endcase

        half_sel = offset_in[1] ? rdata_in[31:16] : rdata_in[15:0];

        ext_bit  = 1'b0;
        data_out = rdata_in;
        case (size_in)
            SZ_B: begin
                ext_bit  = ~unsigned_in & byte_sel[7];
                data_out = {{24{ext_bit}}, byte_sel};
            end
            SZ_H: begin
                ext_bit  = ~unsigned_in & half_sel[15];
                data_out = {{16{ext_bit}}, half_sel};
            end
            default: data_out = rdata_in;
        endcase
    end

endmodule

// File: rtl/msrv32_lsu_stage3.sv
// Stage-3 load/store unit. Takes the registered effective address and rs2 from
// stage 2, runs one req/ack data-bus access per load/store, aligns load data for
// write-back and stalls stages 1-2 while the access is outstanding.
//   clk_in, reset_in            : clock, synchronous active-high reset
//   load_req_in/store_req_in    : stage-2 instruction is a load / store
//   addr_in, store_data_in      : effective address, rs2
//   size_in, load_unsigned_in   : access size, zero-extend select for loads
//   flush_in                    : trap/redirect, kills the current instruction
//   dmem_ack_in/err_in/rdata_in : bus completion, error (qualified by ack), read data
//   dmem_req/we/addr/wdata/wr_mask_out : registered bus request, stable until ack
//   load_data_out               : registered aligned load result
//   lsu_done_out, bus_err_out   : one-cycle completion / error pulses (in RESP)
//   stall_out                   : hold stages 1-2
//   misaligned_load/store_out   : misalignment detect, only while IDLE
//   lsu_state_out               : current FSM state (debug)
// Handshake: dmem_req_out rises on the edge that enters BUSY and stays high, with
// address/data/mask/we frozen, until the edge at which dmem_ack_in is sampled high
// (or the access times out); one access is completed per ack.
module msrv32_lsu_stage3
    import msrv32_pkg::*;
#(
    parameter int              TO_W        = 8,
    parameter logic [TO_W-1:0] ACK_TIMEOUT = 8'd255
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        load_req_in,
    input  logic        store_req_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data_in,
    input  logic [1:0]  size_in,
    input  logic        load_unsigned_in,
    input  logic        flush_in,
    input  logic        dmem_ack_in,
    input  logic        dmem_err_in,
    input  logic [31:0] dmem_rdata_in,
    output logic        dmem_req_out,
    output logic        dmem_we_out,
    output logic [31:0] dmem_addr_out,
    output logic [31:0] dmem_wdata_out,
    output logic [3:0]  dmem_wr_mask_out,
    output logic [31:0] load_data_out,
    output logic        lsu_done_out,
    output logic        stall_out,
    output logic        misaligned_load_out,
    output logic        misaligned_store_out,
    output logic        bus_err_out,
    output logic [1:0]  lsu_state_out
);

    // The counter holds the number of BUSY cycles already spent, so the
    // ACK_TIMEOUT-th BUSY cycle without ack is the one seeing ACK_TIMEOUT-1.
    localparam logic [TO_W-1:0] TO_LAST = ACK_TIMEOUT - 1'b1;

    lsu_state_e      state_q, state_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      mask_q, mask_d;
    logic [1:0]      size_q, size_d;
    logic [1:0]      off_q, off_d;
    logic            uns_q, uns_d;
    logic [31:0]     ld_data_q, ld_data_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            kill_q, kill_d;
    logic [TO_W-1:0] cnt_q, cnt_d;

    logic            mis;
    logic            request;
    logic            kill_now;
    logic [31:0]     st_wdata;
    logic [3:0]      st_mask;
    logic [31:0]     align_data;

    msrv32_load_align u_align (
        .rdata_in    (dmem_rdata_in),
        .offset_in   (off_q),
        .size_in     (size_q),
        .unsigned_in (uns_q),
        .data_out    (align_data)
    );

    // Store lane replication and byte enables from the stage-2 inputs.
    always_comb begin
        case (size_in)
            SZ_B: begin
                st_wdata = {4{store_data_in[7:0]}};
                st_mask  = 4'b0001 << addr_in[1:0];
            end
            SZ_H: begin
                st_wdata = {2{store_data_in[15:0]}};
                st_mask  = 4'b0011 << {addr_in[1], 1'b0};
            end
            default: begin
                st_wdata = store_data_in;
                st_mask  = 4'b1111;
            end
        endcase
    end

    always_comb begin
        mis                  = is_misaligned(size_in, addr_in[1:0]);
        request              = (load_req_in | store_req_in) & ~flush_in & ~mis;
        misaligned_load_out  = (state_q == LSU_IDLE) & load_req_in & mis;
        misaligned_store_out = (state_q == LSU_IDLE) & store_req_in & mis;
    end

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        mask_d    = mask_q;
        size_d    = size_q;
        off_d     = off_q;
        uns_d     = uns_q;
        ld_data_d = ld_data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        kill_d    = kill_q;
        cnt_d     = cnt_q;
        stall_out = 1'b0;
        kill_now  = kill_q | flush_in;

        case (state_q)
            LSU_IDLE: begin
                stall_out = request;
                if (request) begin
                    state_d = LSU_BUSY;
                    req_d   = 1'b1;
                    we_d    = store_req_in;
                    addr_d  = {addr_in[31:2], 2'b00};
                    wdata_d = store_req_in ? st_wdata : 32'd0;
                    mask_d  = store_req_in ? st_mask : 4'b0000;
                    size_d  = size_in;
                    off_d   = addr_in[1:0];
                    uns_d   = load_unsigned_in;
                    kill_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            LSU_BUSY: begin
                stall_out = 1'b1;
                cnt_d     = cnt_q + 1'b1;
                kill_d    = kill_now;
                // A flushed access still runs to completion on the bus but
                // leaves no architectural trace: no pulses, load data untouched.
                if (dmem_ack_in) begin
                    req_d  = 1'b0;
                    kill_d = 1'b0;
                    if (kill_now) begin
                        state_d = LSU_IDLE;
                    end else begin
                        state_d = LSU_RESP;
                        done_d  = 1'b1;
                        err_d   = dmem_err_in;
                        if (!we_q) begin
                            ld_data_d = align_data;
                        end
                    end
                end else if (cnt_q == TO_LAST) begin
                    req_d  = 1'b0;
                    kill_d = 1'b0;
                    if (kill_now) begin
                        state_d = LSU_IDLE;
                    end else begin
                        state_d   = LSU_RESP;
                        done_d    = 1'b1;
                        err_d     = 1'b1;
                        ld_data_d = 32'd0;
                    end
                end
            end
            LSU_RESP: begin
                // Stage-2 inputs still show the finished instruction here.
                state_d = LSU_IDLE;
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q   <= LSU_IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            mask_q    <= 4'b0000;
            size_q    <= SZ_B;
            off_q     <= 2'b00;
            uns_q     <= 1'b0;
            ld_data_q <= 32'd0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            kill_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            mask_q    <= mask_d;
            size_q    <= size_d;
            off_q     <= off_d;
            uns_q     <= uns_d;
            ld_data_q <= ld_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
            kill_q    <= kill_d;
            cnt_q     <= cnt_d;
        end
    end

    assign dmem_req_out     = req_q;
    assign dmem_we_out      = we_q;
    assign dmem_addr_out    = addr_q;
    assign dmem_wdata_out   = wdata_q;
    assign dmem_wr_mask_out = mask_q;
    assign load_data_out    = ld_data_q;
    assign lsu_done_out     = done_q;
    assign bus_err_out      = err_q;
    assign lsu_state_out    = state_q;

endmodule

// File: tb/tb_msrv32_lsu_stage3.sv
// Bench for msrv32_lsu_stage3: directed scenarios followed by randomized
// loads/stores, checked against a byte-arithmetic reference model.
module tb_msrv32_lsu_stage3;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        load_req_in;
    logic        store_req_in;
    logic [31:0] addr_in;
    logic [31:0] store_data_in;
    logic [1:0]  size_in;
    logic        load_unsigned_in;
    logic        flush_in;
    logic        dmem_ack_in;
    logic        dmem_err_in;
    logic [31:0] dmem_rdata_in;
    logic        dmem_req_out;
    logic        dmem_we_out;
    logic [31:0] dmem_addr_out;
    logic [31:0] dmem_wdata_out;
    logic [3:0]  dmem_wr_mask_out;
    logic [31:0] load_data_out;
    logic        lsu_done_out;
    logic        stall_out;
    logic        misaligned_load_out;
    logic        misaligned_store_out;
    logic        bus_err_out;
    logic [1:0]  lsu_state_out;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_ld = 32'd0;

    msrv32_lsu_stage3 dut (
        .clk_in               (clk_in),
        .reset_in             (reset_in),
        .load_req_in          (load_req_in),
        .store_req_in         (store_req_in),
        .addr_in              (addr_in),
        .store_data_in        (store_data_in),
        .size_in              (size_in),
        .load_unsigned_in     (load_unsigned_in),
        .flush_in             (flush_in),
        .dmem_ack_in          (dmem_ack_in),
        .dmem_err_in          (dmem_err_in),
        .dmem_rdata_in        (dmem_rdata_in),
        .dmem_req_out         (dmem_req_out),
        .dmem_we_out          (dmem_we_out),
        .dmem_addr_out        (dmem_addr_out),
        .dmem_wdata_out       (dmem_wdata_out),
        .dmem_wr_mask_out     (dmem_wr_mask_out),
        .load_data_out        (load_data_out),
        .lsu_done_out         (lsu_done_out),
        .stall_out            (stall_out),
        .misaligned_load_out  (misaligned_load_out),
        .misaligned_store_out (misaligned_store_out),
        .bus_err_out          (bus_err_out),
        .lsu_state_out        (lsu_state_out)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk_in = ~clk_in;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int size_bytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [1:0] off,
                                             input logic [1:0] sz, input logic uns);
        longint unsigned span;
        longint unsigned raw;
        longint          val;
        span = 64'd1 << (8 * size_bytes(sz));
        raw  = ({32'd0, rd} >> (8 * int'(off))) % span;
        val  = longint'(raw);
        if (!uns && raw >= span / 2) val = val - longint'(span);
        return val[31:0];
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [31:0] d, input logic [1:0] sz);
        int nb;
        nb = size_bytes(sz);
        if (nb == 1) return (d % 32'd256) * 32'h0101_0101;
        if (nb == 2) return (d % 32'd65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [3:0] ref_mask(input logic [1:0] off, input logic [1:0] sz);
        logic [31:0] m;
        m = ((32'd1 << size_bytes(sz)) - 32'd1) << off;
        return m[3:0];
    endfunction

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        load_req_in      = 1'b0;
        store_req_in     = 1'b0;
        addr_in          = 32'd0;
        store_data_in    = 32'd0;
        size_in          = 2'd0;
        load_unsigned_in = 1'b0;
        flush_in         = 1'b0;
        dmem_ack_in      = 1'b0;
        dmem_err_in      = 1'b0;
        dmem_rdata_in    = 32'd0;
    endtask

    task automatic drive_req(input logic ld, input logic [31:0] addr, input logic [31:0] data,
                             input logic [1:0] sz, input logic uns);
        load_req_in      = ld;
        store_req_in     = ~ld;
        addr_in          = addr;
        store_data_in    = data;
        size_in          = sz;
        load_unsigned_in = uns;
    endtask

    // One complete access. ack_dly = number of BUSY cycles until ack (ack is
    // driven in that cycle); 0 means never ack, forcing the timeout path.
    task automatic run_access(input logic ld, input logic [31:0] addr, input logic [31:0] data,
                              input logic [1:0] sz, input logic uns, input int ack_dly,
                              input logic [31:0] rdata, input logic err);
        int          c;
        int          req_cyc;
        int          stall_cyc;
        int          exp_req;
        logic [31:0] exp_ld;
        if (ack_dly == 0)  exp_ld = 32'd0;
        else if (ld)       exp_ld = ref_load(rdata, addr[1:0], sz, uns);
        else               exp_ld = last_ld;
        exp_q.push_back(exp_ld);
        exp_req = (ack_dly == 0) ? 255 : ack_dly;

        @(posedge clk_in); #1;
        drive_req(ld, addr, data, sz, uns);
        #1;
        check("issue_stall", {31'd0, stall_out}, 32'd1);
        stall_cyc = 1;
        req_cyc   = 0;
        c         = 0;
        while (!lsu_done_out && c < 400) begin
            @(posedge clk_in); #1;
            if (dmem_ack_in) begin
                dmem_ack_in = 1'b0;
                dmem_err_in = 1'b0;
            end
            if (!lsu_done_out) begin
                c++;
                if (dmem_req_out) req_cyc++;
                if (stall_out) stall_cyc++;
                if (c == 1) begin
                    check("busy_addr", dmem_addr_out, {addr[31:2], 2'b00});
                    check("busy_we", {31'd0, dmem_we_out}, {31'd0, ~ld});
                    check("busy_mask", {28'd0, dmem_wr_mask_out},
                          ld ? 32'd0 : {28'd0, ref_mask(addr[1:0], sz)});
                    if (!ld) check("busy_wdata", dmem_wdata_out, ref_wdata(data, sz));
                end
                if (c == ack_dly) begin
                    dmem_ack_in   = 1'b1;
                    dmem_err_in   = err;
                    dmem_rdata_in = rdata;
                end
            end
        end
        check("done_within_bound", {31'd0, lsu_done_out}, 32'd1);
        check("resp_stall", {31'd0, stall_out}, 32'd0);
        check("resp_req_low", {31'd0, dmem_req_out}, 32'd0);
        check("resp_bus_err", {31'd0, bus_err_out}, (ack_dly == 0) ? 32'd1 : {31'd0, err});
        check("resp_load_data", load_data_out, exp_q.pop_front());
        check("req_cycles", req_cyc, exp_req);
        check("stall_cycles", stall_cyc, exp_req + 1);
        last_ld = exp_ld;

        @(posedge clk_in); #1;
        drive_idle();
        check("done_one_cycle", {31'd0, lsu_done_out}, 32'd0);
        check("err_one_cycle", {31'd0, bus_err_out}, 32'd0);
        check("back_to_idle", {30'd0, lsu_state_out}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic        ld;
        logic [1:0]  sz;
        logic [1:0]  off;
        logic [31:0] a;

        drive_idle();
        reset_in = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        check("rst_req", {31'd0, dmem_req_out}, 32'd0);
        check("rst_we", {31'd0, dmem_we_out}, 32'd0);
        check("rst_addr", dmem_addr_out, 32'd0);
        check("rst_wdata", dmem_wdata_out, 32'd0);
        check("rst_mask", {28'd0, dmem_wr_mask_out}, 32'd0);
        check("rst_load_data", load_data_out, 32'd0);
        check("rst_done", {31'd0, lsu_done_out}, 32'd0);
        check("rst_bus_err", {31'd0, bus_err_out}, 32'd0);
        check("rst_state", {30'd0, lsu_state_out}, 32'd0);
        reset_in = 1'b0;

        // LW, ack in 3rd BUSY cycle
        run_access(1'b1, 32'h0000_0100, 32'd0, 2'd2, 1'b0, 3, 32'hDEAD_BEEF, 1'b0);
        check("lw_value", load_data_out, 32'hDEAD_BEEF);
        // LB at offset 3, signed and unsigned
        run_access(1'b1, 32'h0000_0103, 32'd0, 2'd0, 1'b0, 1, 32'h8012_3456, 1'b0);
        check("lb_signed", load_data_out, 32'hFFFF_FF80);
        run_access(1'b1, 32'h0000_0103, 32'd0, 2'd0, 1'b1, 2, 32'h8012_3456, 1'b0);
        check("lbu_value", load_data_out, 32'h0000_0080);
        // SH at offset 2
        run_access(1'b0, 32'h0000_0202, 32'h1234_ABCD, 2'd1, 1'b0, 2, 32'd0, 1'b0);
        // Bus error on ack
        run_access(1'b1, 32'h0000_0500, 32'd0, 2'd1, 1'b0, 2, 32'h1234_F00D, 1'b1);

        // Misaligned load / store: no bus access, no stall
        @(posedge clk_in); #1;
        drive_req(1'b1, 32'h0000_0101, 32'd0, 2'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("mis_lw_flag", {31'd0, misaligned_load_out}, 32'd1);
            check("mis_lw_stall", {31'd0, stall_out}, 32'd0);
            @(posedge clk_in); #1;
            check("mis_lw_no_req", {31'd0, dmem_req_out}, 32'd0);
        end
        drive_req(1'b0, 32'h0000_0203, 32'hFFFF_FFFF, 2'd1, 1'b0);
        #1;
        check("mis_sh_flag", {31'd0, misaligned_store_out}, 32'd1);
        check("mis_sh_load_flag", {31'd0, misaligned_load_out}, 32'd0);
        @(posedge clk_in); #1;
        check("mis_sh_no_req", {31'd0, dmem_req_out}, 32'd0);
        drive_req(1'b1, 32'h0000_0102, 32'd0, 2'd1, 1'b0);
        #1;
        check("aligned_lh_no_flag", {31'd0, misaligned_load_out}, 32'd0);
        drive_idle();

        // Timeout: no ack at all
        run_access(1'b1, 32'h0000_0600, 32'd0, 2'd2, 1'b0, 0, 32'd0, 1'b0);

        // Reload a known value, then flush an access in BUSY
        run_access(1'b1, 32'h0000_0700, 32'd0, 2'd2, 1'b0, 1, 32'h5555_AAAA, 1'b0);
        @(posedge clk_in); #1;
        drive_req(1'b1, 32'h0000_0400, 32'd0, 2'd2, 1'b0);
        @(posedge clk_in); #1;
        check("flush_busy_req", {31'd0, dmem_req_out}, 32'd1);
        flush_in    = 1'b1;
        load_req_in = 1'b0;
        @(posedge clk_in); #1;
        flush_in = 1'b0;
        check("flush_still_req", {31'd0, dmem_req_out}, 32'd1);
        check("flush_still_stall", {31'd0, stall_out}, 32'd1);
        dmem_ack_in   = 1'b1;
        dmem_rdata_in = 32'h0BAD_0BAD;
        @(posedge clk_in); #1;
        dmem_ack_in = 1'b0;
        check("flush_no_done", {31'd0, lsu_done_out}, 32'd0);
        check("flush_no_err", {31'd0, bus_err_out}, 32'd0);
        check("flush_idle", {30'd0, lsu_state_out}, 32'd0);
        check("flush_req_low", {31'd0, dmem_req_out}, 32'd0);
        check("flush_data_kept", load_data_out, last_ld);
        @(posedge clk_in); #1;
        check("flush_no_done_later", {31'd0, lsu_done_out}, 32'd0);

        // Reset in BUSY drops the request on the next edge
        drive_req(1'b1, 32'h0000_0300, 32'd0, 2'd2, 1'b0);
        @(posedge clk_in); #1;
        check("rst_busy_req", {31'd0, dmem_req_out}, 32'd1);
        reset_in    = 1'b1;
        load_req_in = 1'b0;
        @(posedge clk_in); #1;
        reset_in = 1'b0;
        check("rst_mid_req", {31'd0, dmem_req_out}, 32'd0);
        check("rst_mid_state", {30'd0, lsu_state_out}, 32'd0);
        check("rst_mid_load_data", load_data_out, 32'd0);
        last_ld = 32'd0;

        // Randomized accesses
        for (int n = 0; n < 24; n++) begin
            ld  = 1'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 3));
            off = (size_bytes(sz) == 1) ? 2'($urandom_range(0, 3)) :
                  (size_bytes(sz) == 2) ? 2'(2 * $urandom_range(0, 1)) : 2'd0;
            a   = ($urandom & 32'hFFFF_FFFC) | {30'd0, off};
            run_access(ld, a, $urandom, sz, 1'($urandom_range(0, 1)),
                       $urandom_range(1, 6), $urandom, ($urandom_range(0, 7) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
